// File: rtl/rx_record_assembler_if.sv
// Record assembler bundle: decoded-symbol input, FWFT record read port and status counters.
// master = symbol source / record consumer side, slave = assembler side.
interface rx_record_assembler_if #(
  parameter int BYTES_PER_WORD = 3,
  parameter int FIFO_DEPTH     = 16,
  parameter int CNT_WIDTH      = 8
);
  localparam int W   = 8 * BYTES_PER_WORD;
  localparam int SZW = $clog2(FIFO_DEPTH) + 1;

  logic                 CNT_CLEAR;
  logic                 KEEP_PARTIAL;
  logic                 DEC_VALID;
  logic                 DEC_K;
  logic [7:0]           DEC_DATA;
  logic                 DEC_ERR;
  logic [W+1:0]         DATA_OUT;
  logic                 DATA_VALID;
  logic                 DATA_READY;
  logic                 FIFO_FULL;
  logic [SZW-1:0]       FIFO_SIZE;
  logic [CNT_WIDTH-1:0] LOST_ERR_CNT;
  logic [CNT_WIDTH-1:0] DECODER_ERR_CNT;
  logic [CNT_WIDTH-1:0] K_CNT;

  modport master (
    output CNT_CLEAR, KEEP_PARTIAL, DEC_VALID, DEC_K, DEC_DATA, DEC_ERR, DATA_READY,
    input  DATA_OUT, DATA_VALID, FIFO_FULL, FIFO_SIZE, LOST_ERR_CNT, DECODER_ERR_CNT, K_CNT
  );

  modport slave (
    input  CNT_CLEAR, KEEP_PARTIAL, DEC_VALID, DEC_K, DEC_DATA, DEC_ERR, DATA_READY,
    output DATA_OUT, DATA_VALID, FIFO_FULL, FIFO_SIZE, LOST_ERR_CNT, DECODER_ERR_CNT, K_CNT
  );
endinterface

// File: rtl/rx_record_assembler.sv
// Packs decoded bytes into SOF/PARTIAL-tagged records; final byte to DATA_VALID is 2 cycles.
// FWFT record FIFO with valid/ready pop; a push into a full FIFO without a same-cycle pop is dropped and counted.
module rx_record_assembler #(
  parameter int BYTES_PER_WORD = 3,
  parameter int FIFO_DEPTH     = 16,
  parameter int CNT_WIDTH      = 8
) (
  input logic                  WCLK,
  input logic                  RESET,
  rx_record_assembler_if.slave bus
);
  localparam int W   = 8 * BYTES_PER_WORD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int SZW = AW + 1;
  localparam int SW  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef logic [W+1:0] rec_t;

  logic [SW-1:0]                  byte_sel_q, byte_sel_d;
  logic [BYTES_PER_WORD-1:0][7:0] lane_q, lane_d;
  logic                           sof_pending_q, sof_pending_d;
  logic                           push_vld_q, push_vld_d;
  rec_t                           push_dat_q, push_dat_d;
  logic [AW-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [SZW-1:0]                 size_q, size_d;
  logic [CNT_WIDTH-1:0]           lost_cnt_q, lost_cnt_d;
  logic [CNT_WIDTH-1:0]           err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]           k_cnt_q, k_cnt_d;
  rec_t                           mem_q [FIFO_DEPTH];

  logic [W-1:0] partial_pay;
  logic [W-1:0] full_pay;
  logic         data_valid;
  logic         fifo_full;
  logic         pop;
  logic         wr_ok;
  logic         lost;

  function automatic logic [CNT_WIDTH-1:0] cnt_next(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 inc,
    input logic                 clr
  );
    if (clr) return '0;
    if (inc && (cur != '1)) return cur + 1'b1;
    return cur;
  endfunction

  // Lane 0 is the first byte received and lands in the payload MSBs.
  always_comb begin
    partial_pay = '0;
    full_pay    = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (i < int'(byte_sel_q)) partial_pay[W-1-8*i -: 8] = lane_q[i];
      full_pay[W-1-8*i -: 8] = (i == BYTES_PER_WORD - 1) ? bus.DEC_DATA : lane_q[i];
    end
  end

  always_comb begin
    byte_sel_d    = byte_sel_q;
    lane_d        = lane_q;
    sof_pending_d = sof_pending_q;
    push_vld_d    = 1'b0;
    push_dat_d    = push_dat_q;
    if (bus.DEC_VALID) begin
      if (bus.DEC_ERR) begin
        byte_sel_d = '0;
      end else if (bus.DEC_K) begin
        byte_sel_d    = '0;
        sof_pending_d = 1'b1;
        if ((byte_sel_q != '0) && bus.KEEP_PARTIAL) begin
          push_vld_d = 1'b1;
          push_dat_d = {sof_pending_q, 1'b1, partial_pay};
        end
      end else begin
        lane_d[byte_sel_q] = bus.DEC_DATA;
        if (byte_sel_q == SW'(BYTES_PER_WORD - 1)) begin
          push_vld_d    = 1'b1;
          push_dat_d    = {sof_pending_q, 1'b0, full_pay};
          sof_pending_d = 1'b0;
          byte_sel_d    = '0;
        end else begin
          byte_sel_d = byte_sel_q + 1'b1;
        end
      end
    end
  end

  // Occupancy counts to FIFO_DEPTH, so its MSB alone marks full.
  assign data_valid = (size_q != '0);
  assign fifo_full  = size_q[AW];
  assign pop        = data_valid && bus.DATA_READY;
  assign wr_ok      = push_vld_q && (!fifo_full || pop);
  assign lost       = push_vld_q && fifo_full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    size_d     = size_q + SZW'(wr_ok) - SZW'(pop);
    lost_cnt_d = cnt_next(lost_cnt_q, lost, bus.CNT_CLEAR);
    err_cnt_d  = cnt_next(err_cnt_q, bus.DEC_VALID && bus.DEC_ERR, bus.CNT_CLEAR);
    k_cnt_d    = cnt_next(k_cnt_q, bus.DEC_VALID && !bus.DEC_ERR && bus.DEC_K, bus.CNT_CLEAR);
  end

  always_ff @(posedge WCLK or posedge RESET) begin
    if (RESET) begin
      byte_sel_q    <= '0;
      lane_q        <= '0;
      sof_pending_q <= 1'b0;
      push_vld_q    <= 1'b0;
      push_dat_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      size_q        <= '0;
      lost_cnt_q    <= '0;
      err_cnt_q     <= '0;
      k_cnt_q       <= '0;
    end else begin
      byte_sel_q    <= byte_sel_d;
      lane_q        <= lane_d;
      sof_pending_q <= sof_pending_d;
      push_vld_q    <= push_vld_d;
      push_dat_q    <= push_dat_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      size_q        <= size_d;
      lost_cnt_q    <= lost_cnt_d;
      err_cnt_q     <= err_cnt_d;
      k_cnt_q       <= k_cnt_d;
    end
  end

  // Storage needs no reset: nothing is visible unless occupancy says so.
  always_ff @(posedge WCLK) begin
    if (wr_ok) mem_q[wr_ptr_q] <= push_dat_q;
  end

  assign bus.DATA_OUT        = data_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.DATA_VALID      = data_valid;
  assign bus.FIFO_FULL       = fifo_full;
  assign bus.FIFO_SIZE       = size_q;
  assign bus.LOST_ERR_CNT    = lost_cnt_q;
  assign bus.DECODER_ERR_CNT = err_cnt_q;
  assign bus.K_CNT           = k_cnt_q;
endmodule
